// File: rtl/axi4l_reg_bank.sv
// AXI4-Lite slave register bank: NUM_REGS byte-strobed read/write registers
// exposed to the fabric through reg_q, with a one-cycle commit strobe per
// register. One outstanding write and one outstanding read; AW and W are
// buffered independently, so they may arrive in any order.
module axi4l_reg_bank #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    input  logic [ADDR_WIDTH-1:0]          awaddr,
    input  logic                           awprot,
    input  logic                           awvalid,
    output logic                           awready,
    input  logic [DATA_WIDTH-1:0]          wdata,
    input  logic [DATA_WIDTH/8-1:0]        wstrb,
    input  logic                           wvalid,
    output logic                           wready,
    output logic [1:0]                     bresp,
    output logic                           bvalid,
    input  logic                           bready,
    input  logic [ADDR_WIDTH-1:0]          araddr,
    input  logic                           arprot,
    input  logic                           arvalid,
    output logic                           arready,
    output logic [DATA_WIDTH-1:0]          rdata,
    output logic [1:0]                     rresp,
    output logic                           rvalid,
    input  logic                           rready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]            reg_wr_stb
);

    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int BOFS   = $clog2(NBYTES);
    localparam int IDXW   = ADDR_WIDTH - BOFS;
    localparam logic [IDXW:0] NUM_REGS_W = (IDXW+1)'(NUM_REGS);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Write-side holding buffers and response state
    logic                  aw_full_reg;
    logic [IDXW-1:0]       aw_idx_reg;
    logic                  w_full_reg;
    logic [DATA_WIDTH-1:0] w_data_reg;
    logic [NBYTES-1:0]     w_strb_reg;
    logic                  bvalid_reg;
    logic [1:0]            bresp_reg;
    logic [NUM_REGS-1:0]   wr_stb_reg;

    // Read-side response state
    logic                  rvalid_reg;
    logic [1:0]            rresp_reg;
    logic [DATA_WIDTH-1:0] rdata_reg;

    logic [DATA_WIDTH-1:0] regs_reg [NUM_REGS];

    logic                  aw_hs, w_hs, ar_hs, commit;
    logic [IDXW-1:0]       ar_idx;
    logic                  wr_in_range, rd_in_range;
    logic [NUM_REGS-1:0]   wr_sel, rd_sel;
    logic [DATA_WIDTH-1:0] rd_mux;
    logic                  unused_bits;

    // Readies are gated by aresetn so they stay low while reset is asserted
    assign awready = aresetn & ~aw_full_reg & ~bvalid_reg;
    assign wready  = aresetn & ~w_full_reg & ~bvalid_reg;
    assign arready = aresetn & ~rvalid_reg;

    assign aw_hs  = awvalid & awready;
    assign w_hs   = wvalid & wready;
    assign ar_hs  = arvalid & arready;
    // Both halves present and no response pending: the write lands this edge
    assign commit = aw_full_reg & w_full_reg & ~bvalid_reg;

    assign ar_idx      = araddr[ADDR_WIDTH-1:BOFS];
    assign wr_in_range = {1'b0, aw_idx_reg} < NUM_REGS_W;
    assign rd_in_range = {1'b0, ar_idx} < NUM_REGS_W;

    assign bvalid     = bvalid_reg;
    assign bresp      = bresp_reg;
    assign rvalid     = rvalid_reg;
    assign rresp      = rresp_reg;
    assign rdata      = rdata_reg;
    assign reg_wr_stb = wr_stb_reg;

    // Protection bits and sub-word address bits carry no meaning here
    assign unused_bits = ^{awprot, arprot, awaddr[BOFS-1:0], araddr[BOFS-1:0]};

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            assign wr_sel[gi] = (aw_idx_reg == IDXW'(gi));
            assign rd_sel[gi] = (ar_idx == IDXW'(gi));
            assign reg_q[gi*DATA_WIDTH +: DATA_WIDTH] = regs_reg[gi];

            // Register gi: only strobed bytes change on a commit addressed to it
            always_ff @(posedge aclk or negedge aresetn) begin
                if (!aresetn) begin
                    regs_reg[gi] <= RESET_VAL;
                end else if (commit && wr_sel[gi]) begin
                    for (int b = 0; b < NBYTES; b++) begin
                        if (w_strb_reg[b]) begin
                            regs_reg[gi][8*b +: 8] <= w_data_reg[8*b +: 8];
                        end
                    end
                end
            end
        end
    endgenerate

    // Read data select; out-of-range indices match no register and read zero
    always_comb begin
        rd_mux = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (rd_sel[k]) begin
                rd_mux = regs_reg[k];
            end
        end
    end

    // AW/W buffering, commit and B channel
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            aw_full_reg <= 1'b0;
            aw_idx_reg  <= '0;
            w_full_reg  <= 1'b0;
            w_data_reg  <= '0;
            w_strb_reg  <= '0;
            bvalid_reg  <= 1'b0;
            bresp_reg   <= RESP_OKAY;
            wr_stb_reg  <= '0;
        end else begin
            wr_stb_reg <= '0;
            if (aw_hs) begin
                aw_full_reg <= 1'b1;
                aw_idx_reg  <= awaddr[ADDR_WIDTH-1:BOFS];
            end
            if (w_hs) begin
                w_full_reg <= 1'b1;
                w_data_reg <= wdata;
                w_strb_reg <= wstrb;
            end
            if (commit) begin
                aw_full_reg <= 1'b0;
                w_full_reg  <= 1'b0;
                bvalid_reg  <= 1'b1;
                bresp_reg   <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
                wr_stb_reg  <= wr_sel;
            end else if (bvalid_reg && bready) begin
                bvalid_reg <= 1'b0;
            end
        end
    end

    // AR capture and R channel; capture sees pre-commit register contents
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rvalid_reg <= 1'b0;
            rresp_reg  <= RESP_OKAY;
            rdata_reg  <= '0;
        end else if (ar_hs) begin
            rvalid_reg <= 1'b1;
            rresp_reg  <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
            rdata_reg  <= rd_in_range ? rd_mux : '0;
        end else if (rvalid_reg && rready) begin
            rvalid_reg <= 1'b0;
        end
    end

endmodule
